// File: rtl/mem_arbiter_n.sv
// N-port line arbiter in front of one L2 port; `ARB_RR_EN selects round-robin, else fixed priority (port 0 highest).
// Grant one cycle after a request is seen in IDLE; one transaction in flight, later req_* changes ignored until mem_resp.
module mem_arbiter_n #(
    parameter int NPORT  = 2,
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NPORT-1:0]          req_read,
    input  logic [NPORT-1:0]          req_write,
    input  logic [NPORT*ADDR_W-1:0]   req_addr,
    input  logic [NPORT*LINE_W-1:0]   req_wdata,
    output logic [NPORT-1:0]          req_resp,
    output logic [LINE_W-1:0]         req_rdata,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic                      mem_resp,
    input  logic [LINE_W-1:0]         mem_rdata,
    output logic [NPORT-1:0]          grant,
    output logic                      busy
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state_q, state_d;
    logic [NPORT-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;

    logic [NPORT-1:0]    req_any;
    logic                win_vld;
    logic [NPORT-1:0]    win_oh;
    int                  win_sel;

    assign req_any = req_read | req_write;

`ifdef ARB_RR_EN
    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gnt_idx;
    int            scan;

    // Scan starts at ptr and wraps, so the last winner drops to lowest priority.
    always_comb begin
        win_vld = 1'b0;
        win_oh  = '0;
        win_sel = 0;
        scan    = 0;
        for (int i = 0; i < NPORT; i++) begin
            scan = (int'(ptr_q) + i) % NPORT;
            if (!win_vld && req_any[scan]) begin
                win_vld       = 1'b1;
                win_sel       = scan;
                win_oh[scan]  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (grant_q[i]) gnt_idx = PW'(i);
        end
    end
`else
    always_comb begin
        win_vld = 1'b0;
        win_oh  = '0;
        win_sel = 0;
        for (int i = 0; i < NPORT; i++) begin
            if (!win_vld && req_any[i]) begin
                win_vld    = 1'b1;
                win_sel    = i;
                win_oh[i]  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
`ifdef ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = BUSY;
                    grant_d = win_oh;
                    addr_d  = req_addr[win_sel*ADDR_W +: ADDR_W];
                    wdata_d = req_wdata[win_sel*LINE_W +: LINE_W];
                    // A simultaneous read+write is treated as a write.
                    wr_d    = req_write[win_sel];
                    rd_d    = req_read[win_sel] & ~req_write[win_sel];
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    grant_d = '0;
                    addr_d  = '0;
                    wdata_d = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
`ifdef ARB_RR_EN
                    ptr_d   = (gnt_idx == PW'(NPORT-1)) ? '0 : gnt_idx + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
`ifdef ARB_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
`ifdef ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign busy      = (state_q == BUSY);
    assign grant     = grant_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign req_rdata = mem_rdata;
    assign req_resp  = (busy && mem_resp) ? grant_q : '0;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Directed bench for mem_arbiter_n (NPORT=4); expectations follow ARB_RR_EN when it is defined.
module tb_mem_arbiter_n;

    localparam int NPORT  = 4;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NPORT-1:0]         req_read, req_write;
    logic [NPORT*ADDR_W-1:0]  req_addr;
    logic [NPORT*LINE_W-1:0]  req_wdata;
    logic [NPORT-1:0]         req_resp;
    logic [LINE_W-1:0]        req_rdata;
    logic                     mem_read, mem_write;
    logic [ADDR_W-1:0]        mem_addr;
    logic [LINE_W-1:0]        mem_wdata;
    logic                     mem_resp;
    logic [LINE_W-1:0]        mem_rdata;
    logic [NPORT-1:0]         grant;
    logic                     busy;

    int nvec = 0;
    int nerr = 0;

    mem_arbiter_n #(.NPORT(NPORT), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_resp(req_resp), .req_rdata(req_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Request, expect exp_g granted, complete in the first BUSY cycle.
    task automatic run_txn(input string tag, input logic [NPORT-1:0] rd, input logic [NPORT-1:0] wr,
                           input logic [NPORT-1:0] exp_g);
        req_read  = rd;
        req_write = wr;
        tick();
        chk({tag, "_grant"}, LINE_W'(grant), LINE_W'(exp_g));
        req_read  = '0;
        req_write = '0;
        mem_resp  = 1'b1;
        #1;
        chk({tag, "_resp"}, LINE_W'(req_resp), LINE_W'(exp_g));
        tick();
        mem_resp  = 1'b0;
        chk({tag, "_idle"}, LINE_W'(busy), '0);
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a5, pat_dead, pat_junk;
        logic [NPORT-1:0]  exp_g2;
        int rd_cycles, resp_pulses;

        pat_a5   = {32{8'hA5}};
        pat_dead = {8{32'hDEADBEEF}};
        pat_junk = {8{32'h12345678}};

        rst = 1'b1;
        req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        #12;
        chk("rst_grant", LINE_W'(grant), '0);
        chk("rst_busy", LINE_W'(busy), '0);
        chk("rst_mem_read", LINE_W'(mem_read), '0);
        chk("rst_mem_write", LINE_W'(mem_write), '0);
        chk("rst_mem_addr", LINE_W'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_req_resp", LINE_W'(req_resp), '0);
        tick();
        rst = 1'b0;

        // mem_resp while idle must be ignored
        mem_resp = 1'b1;
        #1;
        chk("idle_resp_ignored", LINE_W'(req_resp), '0);
        tick();
        chk("idle_stays_idle", LINE_W'(busy), '0);
        mem_resp = 1'b0;

        // Port 1 read, L2 answers in the 4th BUSY cycle
        req_read = 4'b0010;
        req_addr[1*ADDR_W +: ADDR_W] = 32'h0000_1000;
        tick();
        req_read = '0;
        rd_cycles = 0;
        resp_pulses = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 3) begin
                mem_resp  = 1'b1;
                mem_rdata = pat_a5;
            end
            @(negedge clk);
            if (mem_read) rd_cycles++;
            if (req_resp != '0) resp_pulses++;
            if (k == 0) begin
                chk("rd_grant", LINE_W'(grant), LINE_W'(4'b0010));
                chk("rd_addr", LINE_W'(mem_addr), LINE_W'(32'h0000_1000));
            end
            if (k == 3) begin
                chk("rd_resp", LINE_W'(req_resp), LINE_W'(4'b0010));
                chk("rd_rdata", req_rdata, pat_a5);
            end
            if (k == 4) chk("rd_idle_after", LINE_W'(busy), '0);
            tick();
            mem_resp = 1'b0;
        end
        chk("rd_cycles", LINE_W'(rd_cycles), LINE_W'(4));
        chk("rd_resp_pulses", LINE_W'(resp_pulses), LINE_W'(1));
        mem_rdata = pat_junk;
        #1;
        chk("rdata_idle_passthru", req_rdata, pat_junk);

        // Ports 0 and 1 contend three times
        exp_g2 = 4'b0001;
`ifdef ARB_RR_EN
        exp_g2 = 4'b0010;
`endif
        run_txn("arb1", 4'b0011, 4'b0000, 4'b0001);
        run_txn("arb2", 4'b0011, 4'b0000, exp_g2);
        run_txn("arb3", 4'b0011, 4'b0000, 4'b0001);

        // Port 0 write; its inputs change mid-BUSY
        req_write = 4'b0001;
        req_addr[0 +: ADDR_W]  = 32'h40;
        req_wdata[0 +: LINE_W] = pat_dead;
        tick();
        req_addr[0 +: ADDR_W]  = 32'h80;
        req_wdata[0 +: LINE_W] = pat_junk;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("wr_addr_hold", LINE_W'(mem_addr), LINE_W'(32'h40));
            chk("wr_wdata_hold", mem_wdata, pat_dead);
            chk("wr_mem_write", LINE_W'(mem_write), LINE_W'(1));
            tick();
        end
        mem_resp = 1'b1;
        #1;
        chk("wr_resp", LINE_W'(req_resp), LINE_W'(4'b0001));
        tick();
        mem_resp = 1'b0;
        req_write = '0;
        chk("wr_done_mem_write", LINE_W'(mem_write), '0);

        // Port 2 read+write together resolves to a write
        req_read  = 4'b0100;
        req_write = 4'b0100;
        tick();
        req_read  = '0;
        req_write = '0;
        chk("rw_grant", LINE_W'(grant), LINE_W'(4'b0100));
        chk("rw_mem_write", LINE_W'(mem_write), LINE_W'(1));
        chk("rw_mem_read", LINE_W'(mem_read), '0);
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;

        // Async reset mid-BUSY
        req_read = 4'b1000;
        tick();
        req_read = '0;
        chk("ar_busy_pre", LINE_W'(busy), LINE_W'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_mem_read", LINE_W'(mem_read), '0);
        chk("ar_mem_write", LINE_W'(mem_write), '0);
        chk("ar_grant", LINE_W'(grant), '0);
        chk("ar_busy", LINE_W'(busy), '0);
        #1;
        rst = 1'b0;
        mem_resp = 1'b1;
        #1;
        chk("ar_late_resp", LINE_W'(req_resp), '0);
        tick();
        mem_resp = 1'b0;
        chk("ar_still_idle", LINE_W'(busy), '0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
